// File: rtl/frame_bus_master.sv
// Byte-stream command front end: de-frames UART bytes, performs one peripheral register access, returns a framed reply.
// Optional FRAME_CHECKSUM_EN adds an XOR checksum byte to both the request and the reply payloads.
module frame_bus_master #(
   parameter int         NUM_PERIPH    = 128,
   parameter int         MAX_DATA      = 4,
   parameter int         SELECT_CYCLES = 2,
   parameter logic [7:0] START_CHAR    = 8'h01,
   parameter logic [7:0] ESC_CHAR      = 8'h02,
   parameter logic [7:0] END_CHAR      = 8'h03
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic [7:0]              bus_addr,
   output logic                    bus_rw,
   output logic [8*MAX_DATA-1:0]   bus_wdata,
   input  logic [8*MAX_DATA-1:0]   bus_rdata,
   input  logic [2:0]              bus_size,
   output logic [NUM_PERIPH-1:0]   bus_select,
   output logic                    busy,
   output logic [7:0]              err_count,
   output logic [3:0]              state_dbg
);

`ifdef FRAME_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   localparam logic [3:0] PAY_MAX  = 4'(2 + MAX_DATA + CK);
   localparam logic [3:0] RD_LEN   = 4'(2 + CK);
   localparam logic [3:0] WR_MIN   = 4'(3 + CK);
   localparam logic [2:0] MD3      = 3'(MAX_DATA);
   localparam logic [7:0] SEL_LAST = 8'(SELECT_CYCLES - 1);

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_RECV     = 4'd1,
      ST_CHECK    = 4'd2,
      ST_SETUP    = 4'd3,
      ST_SELECT   = 4'd4,
      ST_TX_START = 4'd5,
      ST_TX_BODY  = 4'd6,
      ST_TX_END   = 4'd7
   } state_t;

   state_t                  state_r, state_s;
   logic [7:0]              buf_r [0:15];
   logic [3:0]              cnt_r;
   logic                    esc_r;
   logic [7:0]              rx_xor_r;
   logic [7:0]              sel_cnt_r;
   logic [8*MAX_DATA-1:0]   rdata_r;
   logic [2:0]              rsize_r;
   logic [3:0]              bidx_r;
   logic                    esc_done_r;
   logic [7:0]              tx_cks_r;
   logic [7:0]              tx_data_r;
   logic                    tx_valid_r;
   logic [7:0]              bus_addr_r;
   logic                    bus_rw_r;
   logic [8*MAX_DATA-1:0]   bus_wdata_r;
   logic [NUM_PERIPH-1:0]   bus_select_r;
   logic [7:0]              err_r;

   logic                    tx_fire_s, restart_s, end_s, esc_set_s, store_s, overflow_s;
   logic                    frame_ok_s, err_inc_s;
   logic [3:0]              ndata_s, blen_s;
   logic [NUM_PERIPH-1:0]   sel_s;
   logic [7:0]              body_byte_s;

   function automatic logic is_special(input logic [7:0] b);
      return (b == START_CHAR) || (b == ESC_CHAR) || (b == END_CHAR);
   endfunction

   // Right-justify the first n received data bytes, first byte most significant
   function automatic logic [8*MAX_DATA-1:0] pack_wdata(input logic [3:0] n);
      logic [8*MAX_DATA-1:0] w;
      w = '0;
      for (int i = 0; i < MAX_DATA; i++) begin
         if (4'(i) < n) begin
            w      = w << 8;
            w[7:0] = buf_r[4'(i + 2)];
         end
      end
      return w;
   endfunction

   function automatic logic [7:0] data_byte(input logic [3:0] j);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < MAX_DATA; i++) begin
         if (4'(i) == j) b = rdata_r[8*i +: 8];
      end
      return b;
   endfunction

   // Receive/decode/transmit helper decode
   always_comb begin
      tx_fire_s  = tx_valid_r && tx_ready;
      restart_s  = (state_r == ST_RECV) && rx_valid && !esc_r && (rx_data == START_CHAR);
      end_s      = (state_r == ST_RECV) && rx_valid && !esc_r && (rx_data == END_CHAR);
      esc_set_s  = (state_r == ST_RECV) && rx_valid && !esc_r && (rx_data == ESC_CHAR);
      store_s    = (state_r == ST_RECV) && rx_valid && !restart_s && !end_s && !esc_set_s;
      overflow_s = store_s && (cnt_r == PAY_MAX);
      ndata_s    = cnt_r - RD_LEN;
      if (buf_r[0][7]) frame_ok_s = (cnt_r == RD_LEN);
      else             frame_ok_s = (cnt_r >= WR_MIN) && (cnt_r <= PAY_MAX);
      if (CK == 1 && rx_xor_r != 8'h00) frame_ok_s = 1'b0;
      else                              frame_ok_s = frame_ok_s;
      for (int i = 0; i < NUM_PERIPH; i++) sel_s[i] = (buf_r[0][6:0] == 7'(i));
      blen_s = RD_LEN + {1'b0, rsize_r};
      if (bidx_r == 4'd0)                        body_byte_s = buf_r[0];
      else if (bidx_r == 4'd1)                   body_byte_s = buf_r[1];
      else if (CK == 1 && bidx_r == blen_s - 4'd1) body_byte_s = tx_cks_r;
      else                                       body_byte_s = data_byte({1'b0, rsize_r} + 4'd1 - bidx_r);
      err_inc_s = restart_s || overflow_s || ((state_r == ST_CHECK) && !frame_ok_s) || (busy && rx_valid);
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= ST_IDLE;
      else        state_r <= state_s;
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:     if (rx_valid && rx_data == START_CHAR) state_s = ST_RECV; else state_s = ST_IDLE;
         ST_RECV:     if (end_s) state_s = ST_CHECK; else if (overflow_s) state_s = ST_IDLE; else state_s = ST_RECV;
         ST_CHECK:    if (frame_ok_s) state_s = ST_SETUP; else state_s = ST_IDLE;
         ST_SETUP:    state_s = ST_SELECT;
         ST_SELECT:   if (sel_cnt_r == SEL_LAST) state_s = ST_TX_START; else state_s = ST_SELECT;
         ST_TX_START: if (tx_fire_s) state_s = ST_TX_BODY; else state_s = ST_TX_START;
         ST_TX_BODY:  if (tx_fire_s && !esc_done_r && bidx_r == blen_s - 4'd1) state_s = ST_TX_END;
                      else state_s = ST_TX_BODY;
         ST_TX_END:   if (tx_fire_s) state_s = ST_IDLE; else state_s = ST_TX_END;
         default:     state_s = ST_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy      = (state_r != ST_IDLE) && (state_r != ST_RECV);
      state_dbg = state_r;
   end

   // Frame buffer, bus access and reply datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) buf_r[i] <= 8'h00;
         cnt_r <= 4'd0; esc_r <= 1'b0; rx_xor_r <= 8'h00; sel_cnt_r <= 8'd0;
         rdata_r <= '0; rsize_r <= 3'd0; bidx_r <= 4'd0; esc_done_r <= 1'b0; tx_cks_r <= 8'h00;
         tx_data_r <= 8'h00; tx_valid_r <= 1'b0; bus_addr_r <= 8'h00; bus_rw_r <= 1'b1;
         bus_wdata_r <= '0; bus_select_r <= '0; err_r <= 8'h00;
      end else begin
         if (err_inc_s && err_r != 8'hFF) err_r <= err_r + 8'd1;
         case (state_r)
            ST_IDLE: begin
               if (rx_valid && rx_data == START_CHAR) begin
                  cnt_r <= 4'd0; esc_r <= 1'b0; rx_xor_r <= 8'h00;
               end
            end
            ST_RECV: begin
               if (restart_s) begin
                  cnt_r <= 4'd0; esc_r <= 1'b0; rx_xor_r <= 8'h00;
               end else if (esc_set_s) begin
                  esc_r <= 1'b1;
               end else if (store_s && !overflow_s) begin
                  buf_r[cnt_r] <= rx_data;
                  cnt_r        <= cnt_r + 4'd1;
                  esc_r        <= 1'b0;
                  rx_xor_r     <= rx_xor_r ^ rx_data;
               end
            end
            ST_CHECK: begin
               if (frame_ok_s) begin
                  bus_addr_r  <= buf_r[1];
                  bus_rw_r    <= buf_r[0][7];
                  bus_wdata_r <= buf_r[0][7] ? '0 : pack_wdata(ndata_s);
               end
            end
            ST_SETUP: begin
               bus_select_r <= sel_s;
               sel_cnt_r    <= 8'd0;
            end
            ST_SELECT: begin
               if (sel_cnt_r == SEL_LAST) begin
                  // An out-of-range index never raised a select: reply carries no data
                  bus_select_r <= '0;
                  rdata_r      <= (bus_rw_r && bus_select_r != '0) ? bus_rdata : '0;
                  rsize_r      <= (!bus_rw_r || bus_select_r == '0) ? 3'd0 : ((bus_size > MD3) ? MD3 : bus_size);
               end else begin
                  sel_cnt_r <= sel_cnt_r + 8'd1;
               end
            end
            ST_TX_START: begin
               if (!tx_valid_r) begin
                  tx_data_r <= START_CHAR; tx_valid_r <= 1'b1;
                  bidx_r <= 4'd0; esc_done_r <= 1'b0; tx_cks_r <= 8'h00;
               end else if (tx_fire_s) begin
                  tx_valid_r <= 1'b0;
               end
            end
            ST_TX_BODY: begin
               if (!tx_valid_r) begin
                  tx_valid_r <= 1'b1;
                  if (is_special(body_byte_s) && !esc_done_r) begin
                     tx_data_r  <= ESC_CHAR;
                     esc_done_r <= 1'b1;
                  end else begin
                     tx_data_r  <= body_byte_s;
                     esc_done_r <= 1'b0;
                     tx_cks_r   <= tx_cks_r ^ body_byte_s;
                  end
               end else if (tx_fire_s) begin
                  tx_valid_r <= 1'b0;
                  if (!esc_done_r) bidx_r <= bidx_r + 4'd1;
               end
            end
            ST_TX_END: begin
               if (!tx_valid_r) begin
                  tx_data_r <= END_CHAR; tx_valid_r <= 1'b1;
               end else if (tx_fire_s) begin
                  tx_valid_r <= 1'b0;
               end
            end
            default: begin
               tx_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data    = tx_data_r;
   assign tx_valid   = tx_valid_r;
   assign bus_addr   = bus_addr_r;
   assign bus_rw     = bus_rw_r;
   assign bus_wdata  = bus_wdata_r;
   assign bus_select = bus_select_r;
   assign err_count  = err_r;

endmodule

// File: tb/tb_frame_bus_master.sv
// Directed bench for frame_bus_master: NUM_PERIPH=8, MAX_DATA=4, SELECT_CYCLES=2, no checksum.
module tb_frame_bus_master;
   localparam int NP = 8;
   localparam int MD = 4;
   localparam int SC = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [7:0]    bus_addr;
   logic          bus_rw;
   logic [8*MD-1:0] bus_wdata;
   logic [8*MD-1:0] bus_rdata;
   logic [2:0]    bus_size;
   logic [NP-1:0] bus_select;
   logic          busy;
   logic [7:0]    err_count;
   logic [3:0]    state_dbg;

   frame_bus_master #(.NUM_PERIPH(NP), .MAX_DATA(MD), .SELECT_CYCLES(SC)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_size(bus_size), .bus_select(bus_select), .busy(busy),
      .err_count(err_count), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int          total_cnt = 0;
   int          bad_cnt = 0;
   logic [7:0]  tx_log[$];
   int          sel_cycles = 0;
   logic [NP-1:0] sel_seen = '0;
   logic [7:0]  sel_addr = 8'h00;
   logic        sel_rw = 1'b0;
   logic [31:0] sel_wdata = 32'h0;
   int          t0, s0, n;

   // Passive capture of accepted tx bytes and select activity
   always @(negedge clk) begin
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (bus_select != '0) begin
         sel_cycles <= sel_cycles + 1;
         sel_seen   <= bus_select;
         sel_addr   <= bus_addr;
         sel_rw     <= bus_rw;
         sel_wdata  <= bus_wdata;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] tx_pack(input int from);
      logic [63:0] v;
      v = 64'h0;
      for (int i = from; i < tx_log.size(); i++) v = (v << 8) | {56'h0, tx_log[i]};
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [95:0] v, input int len);
      for (int k = 0; k < len; k++) send_byte(v[8*(len-1-k) +: 8]);
   endtask

   task automatic wait_idle(input string tag);
      int c = 0;
      repeat (3) @(negedge clk);
      while (state_dbg != 4'd0 && c < 300) begin @(negedge clk); c++; end
      check_eq({tag, "_idle"}, 64'(state_dbg), 64'd0);
   endtask

   task automatic wait_state(input string tag, input logic [3:0] st);
      int c = 0;
      while (state_dbg != st && c < 300) begin @(negedge clk); c++; end
      check_eq({tag, "_reach"}, 64'(state_dbg), 64'(st));
   endtask

   task automatic mark();
      t0 = tx_log.size();
      s0 = sel_cycles;
   endtask

   task automatic check_reply(input string tag, input int exp_sel, input logic [63:0] exp_tx, input int exp_len);
      check_eq({tag, "_selcyc"}, 64'(sel_cycles - s0), 64'(exp_sel));
      check_eq({tag, "_txlen"}, 64'(tx_log.size() - t0), 64'(exp_len));
      check_eq({tag, "_tx"}, tx_pack(t0), exp_tx);
   endtask

   initial begin
      reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
      bus_rdata = '0; bus_size = 3'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
      check_eq("rst_tx_data", 64'(tx_data), 64'd0);
      check_eq("rst_select", 64'(bus_select), 64'd0);
      check_eq("rst_rw", 64'(bus_rw), 64'd1);
      check_eq("rst_addr", 64'(bus_addr), 64'd0);
      check_eq("rst_wdata", 64'(bus_wdata), 64'd0);
      check_eq("rst_err", 64'(err_count), 64'd0);
      check_eq("rst_state", 64'(state_dbg), 64'd0);

      // Read peripheral 5, register 0x10, plus END-to-tx_valid latency
      bus_size = 3'd2; bus_rdata = 32'h0000_1234;
      mark();
      send_frame(96'h01_85_10_03, 4);
      n = 0;
      while (n < 50) begin @(negedge clk); if (tx_valid) break; n++; end
      check_eq("rd_latency", 64'(n), 64'(SC + 3));
      check_eq("rd_state_txs", 64'(state_dbg), 64'd5);
      check_eq("rd_busy", 64'(busy), 64'd1);
      wait_idle("rd");
      check_reply("rd", 2, 64'h0185_1012_3403, 6);
      check_eq("rd_sel", 64'(sel_seen), 64'h20);
      check_eq("rd_rw", 64'(sel_rw), 64'd1);
      check_eq("rd_addr", 64'(sel_addr), 64'h10);

      // Escaped write
      mark();
      send_frame(96'h01_05_20_02_03_03, 6);
      wait_idle("wr");
      check_reply("wr", 2, 64'h0105_2003, 4);
      check_eq("wr_sel", 64'(sel_seen), 64'h20);
      check_eq("wr_rw", 64'(sel_rw), 64'd0);
      check_eq("wr_wdata", 64'(sel_wdata), 64'h3);

      // Read size above MAX_DATA is clamped
      bus_size = 3'd7; bus_rdata = 32'hA1B2_C3D4;
      mark();
      send_frame(96'h01_82_40_03, 4);
      wait_idle("clamp");
      check_reply("clamp", 2, 64'h0182_40A1_B2C3_D403, 8);
      check_eq("clamp_sel", 64'(sel_seen), 64'h04);

      // Escaped address in request, escaped bytes in reply
      bus_size = 3'd1; bus_rdata = 32'h0000_0001;
      mark();
      send_frame(96'h01_81_02_03_03, 5);
      wait_idle("esc");
      check_reply("esc", 2, 64'h0181_0203_0201_03, 7);
      check_eq("esc_addr", 64'(sel_addr), 64'h03);

      // Out-of-range peripheral index
      mark();
      send_frame(96'h01_89_00_03, 4);
      wait_idle("oor");
      check_reply("oor", 0, 64'h0189_0003, 4);

      // Overflow drops the frame
      mark();
      send_frame(96'h01_05_00_11_22_33_44_55_03, 9);
      wait_idle("ovf");
      check_reply("ovf", 0, 64'h0, 0);
      check_eq("ovf_err", 64'(err_count), 64'd1);

      // Restart mid-frame, then a byte arriving during the reply
      bus_size = 3'd1; bus_rdata = 32'h0000_005A;
      mark();
      send_frame(96'h01_85_01_85_00_03, 6);
      check_eq("rs_err", 64'(err_count), 64'd2);
      wait_state("rs", 4'd6);
      send_byte(8'h77);
      wait_idle("rs");
      check_reply("rs", 2, 64'h0185_005A_03, 5);
      check_eq("rs_addr", 64'(sel_addr), 64'h00);
      check_eq("busy_err", 64'(err_count), 64'd3);

      // Read frame with a stray extra byte is invalid
      mark();
      send_frame(96'h01_85_10_11_03, 5);
      wait_idle("inv");
      check_reply("inv", 0, 64'h0, 0);
      check_eq("inv_err", 64'(err_count), 64'd4);

      // Backpressure mid-reply holds tx_data
      begin
         logic [7:0] held;
         int         seen, changes;
         bus_size = 3'd2; bus_rdata = 32'h0000_1234;
         mark();
         send_frame(96'h01_85_10_03, 4);
         n = 0;
         while ((tx_log.size() - t0) < 2 && n < 100) begin @(negedge clk); n++; end
         check_eq("bp_reach", 64'(n < 100), 64'd1);
         @(posedge clk); #1 tx_ready = 1'b0;
         seen = 0; changes = 0; held = 8'h00;
         repeat (10) begin
            @(negedge clk);
            if (tx_valid && seen == 0) begin held = tx_data; seen = 1; end
            else if (tx_valid && tx_data != held) changes++;
         end
         check_eq("bp_valid", 64'(seen), 64'd1);
         check_eq("bp_stable", 64'(changes), 64'd0);
         @(posedge clk); #1 tx_ready = 1'b1;
         wait_idle("bp");
         check_reply("bp", 2, 64'h0185_1012_3403, 6);
      end

      // Asynchronous reset during SELECT
      mark();
      send_frame(96'h01_85_10_03, 4);
      wait_state("ar", 4'd4);
      check_eq("ar_sel_before", 64'(bus_select), 64'h20);
      #1 reset = 1'b0;
      #1;
      check_eq("ar_sel", 64'(bus_select), 64'd0);
      check_eq("ar_state", 64'(state_dbg), 64'd0);
      check_eq("ar_tx_valid", 64'(tx_valid), 64'd0);
      check_eq("ar_err", 64'(err_count), 64'd0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end
endmodule
